// File: rtl/pc_unit.sv
// pc_unit: parametrised program counter for the MIPS fetch stage.
// Prioritised next-PC selection (exception > jump > branch > stall > sequential),
// misaligned-target trapping and a BOOT/RUN/HALT state machine.
// Optional feature: define PC_FETCH_COUNT_EN to add a 32-bit saturating
// fetch_count output that counts accepted fetches.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]      EXC_VECTOR   = 32'h0000_0180,
  parameter int               STEP         = 4,
  parameter int               ALIGN_BITS   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             halt,
  input  logic             resume,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exception,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic             fetch_valid,
  output logic             redirect,
  output logic             addr_err,
  output logic [WIDTH-1:0] bad_addr
`ifdef PC_FETCH_COUNT_EN
  ,
  output logic [31:0]      fetch_count
`endif
);

  // Exception vector truncated (or zero-extended) to the PC width.
  localparam logic [WIDTH-1:0] EXC_PC     = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  // Low bits that must be clear in any redirect target; zero mask when ALIGN_BITS = 0.
  localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] pc_next;
  logic             redirect_next;
  logic             addr_err_next;
  logic [WIDTH-1:0] bad_addr_next;
  logic             jump_misaligned;
  logic             branch_misaligned;

  assign pc_next_seq       = pc + STEP_W;
  assign fetch_valid       = (state == RUN) && !stall;
  assign jump_misaligned   = |(jump_target & ALIGN_MASK);
  assign branch_misaligned = |(branch_target & ALIGN_MASK);

  // Next-state and next-PC selection; redirects win over stall, jump wins over branch.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    redirect_next = 1'b0;
    addr_err_next = 1'b0;
    bad_addr_next = bad_addr;
    case (state)
      BOOT: begin
        // PC stays at the reset vector for the single boot cycle.
        state_next = RUN;
      end
      RUN: begin
        if (exception) begin
          pc_next       = EXC_PC;
          redirect_next = 1'b1;
        end else begin
          if (jump) begin
            redirect_next = 1'b1;
            if (jump_misaligned) begin
              pc_next       = EXC_PC;
              addr_err_next = 1'b1;
              bad_addr_next = jump_target;
            end else begin
              pc_next = jump_target;
            end
          end else if (branch_taken) begin
            redirect_next = 1'b1;
            if (branch_misaligned) begin
              pc_next       = EXC_PC;
              addr_err_next = 1'b1;
              bad_addr_next = branch_target;
            end else begin
              pc_next = branch_target;
            end
          end else if (!stall) begin
            pc_next = pc_next_seq;
          end
          // An exception on the same edge keeps the core running.
          if (halt) begin
            state_next = HALT;
          end
        end
      end
      HALT: begin
        // Only exception or resume wake the unit; everything else is ignored.
        if (exception) begin
          state_next    = RUN;
          pc_next       = EXC_PC;
          redirect_next = 1'b1;
        end else if (resume) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // State, PC and status-pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= BOOT;
      pc       <= RESET_VECTOR;
      redirect <= 1'b0;
      addr_err <= 1'b0;
      bad_addr <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      redirect <= redirect_next;
      addr_err <= addr_err_next;
      bad_addr <= bad_addr_next;
    end
  end

`ifdef PC_FETCH_COUNT_EN
  // Saturating count of edges on which a valid fetch was presented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
    end else if ((state == RUN) && fetch_valid && (fetch_count != 32'hFFFF_FFFF)) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed vectors with hand-computed expectations.
// The driver applies one vector per cycle on the falling edge and queues the
// outputs expected during that cycle; the monitor pops and compares mid-cycle.
// Two instances share stimulus: the default 32-bit unit and an 8-bit unit.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        resume = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        exception = 1'b0;

  logic [31:0] pc32, seq32, bad32;
  logic        fv32, rd32, ae32;
  logic [7:0]  pc8, seq8, bad8;
  logic        fv8, rd8, ae8;
`ifdef PC_FETCH_COUNT_EN
  logic [31:0] cnt32, cnt8;
`endif

  always #5 clk = ~clk;

  pc_unit u32 (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt), .resume(resume),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .exception(exception),
    .pc(pc32), .pc_next_seq(seq32), .fetch_valid(fv32),
    .redirect(rd32), .addr_err(ae32), .bad_addr(bad32)
`ifdef PC_FETCH_COUNT_EN
    , .fetch_count(cnt32)
`endif
  );

  pc_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt), .resume(resume),
    .branch_taken(branch_taken), .branch_target(branch_target[7:0]),
    .jump(jump), .jump_target(jump_target[7:0]), .exception(exception),
    .pc(pc8), .pc_next_seq(seq8), .fetch_valid(fv8),
    .redirect(rd8), .addr_err(ae8), .bad_addr(bad8)
`ifdef PC_FETCH_COUNT_EN
    , .fetch_count(cnt8)
`endif
  );

  typedef struct {
    int          idx;
    bit          sel;   // 0 = 32-bit instance, 1 = 8-bit instance
    logic [31:0] pc;
    logic        fv;
    logic        rd;
    logic        ae;
    logic [31:0] bad;
    bit          chk_cnt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   vec_no = 0;

  function automatic void chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end else begin
      passed++;
    end
  endfunction

  // Apply one vector for a cycle and queue the outputs expected during it.
  task automatic step(input bit s, input bit r, input bit st, input bit h, input bit rs,
                      input bit br, input logic [31:0] btv, input bit j, input logic [31:0] jtv,
                      input bit ex, input logic [31:0] epc, input bit efv, input bit erd,
                      input bit eae, input logic [31:0] ebad, input bit cc, input logic [31:0] ecnt);
    exp_t e;
    @(negedge clk);
    reset = r; stall = st; halt = h; resume = rs;
    branch_taken = br; branch_target = btv; jump = j; jump_target = jtv; exception = ex;
    e.idx = vec_no; e.sel = s; e.pc = epc; e.fv = efv; e.rd = erd; e.ae = eae;
    e.bad = ebad; e.chk_cnt = cc; e.cnt = ecnt;
    sb.push_back(e);
    vec_no++;
  endtask

  // Monitor: mid-cycle, compare the selected instance against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] a_pc, a_seq, a_bad, e_seq;
    logic        a_fv, a_rd, a_ae;
    #3;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel) begin
        a_pc = {24'd0, pc8}; a_seq = {24'd0, seq8}; a_bad = {24'd0, bad8};
        a_fv = fv8; a_rd = rd8; a_ae = ae8;
        e_seq = (e.pc + 32'd4) & 32'h0000_00FF;
      end else begin
        a_pc = pc32; a_seq = seq32; a_bad = bad32;
        a_fv = fv32; a_rd = rd32; a_ae = ae32;
        e_seq = e.pc + 32'd4;
      end
      chk("pc", e.idx, a_pc, e.pc);
      chk("pc_next_seq", e.idx, a_seq, e_seq);
      chk("fetch_valid", e.idx, {31'd0, a_fv}, {31'd0, e.fv});
      chk("redirect", e.idx, {31'd0, a_rd}, {31'd0, e.rd});
      chk("addr_err", e.idx, {31'd0, a_ae}, {31'd0, e.ae});
      chk("bad_addr", e.idx, a_bad, e.bad);
`ifdef PC_FETCH_COUNT_EN
      if (e.chk_cnt) begin
        chk("fetch_count", e.idx, cnt32, e.cnt);
      end
`endif
      $display("vec %0d sel=%0d pc=%h fv=%0b rd=%0b ae=%0b bad=%h", e.idx, e.sel,
               a_pc, a_fv, a_rd, a_ae, a_bad);
    end
  end

  initial begin
    int n;
    //    s r st h rs br bt        j  jt         ex  pc         fv rd ae bad       cc cnt
    // Reset release, sequential fetch, stall with branch.
    step(0,0, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h0,   0,0,0,32'h0,  0,0);
    step(0,0, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h0,   0,0,0,32'h0,  0,0);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h0,   0,0,0,32'h0,  0,0);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h0,   1,0,0,32'h0,  0,0);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h4,   1,0,0,32'h0,  0,0);
    step(0,1, 1,0,0, 0,32'h0,   0,32'h0,   0, 32'h8,   0,0,0,32'h0,  0,0);
    step(0,1, 1,0,0, 0,32'h0,   0,32'h0,   0, 32'h8,   0,0,0,32'h0,  0,0);
    step(0,1, 1,0,0, 1,32'h40,  0,32'h0,   0, 32'h8,   0,0,0,32'h0,  0,0);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h40,  1,1,0,32'h0,  0,0);
    // Jump beats branch; misaligned jump and branch trap to the exception vector.
    step(0,1, 0,0,0, 1,32'h200, 1,32'h100, 0, 32'h44,  1,0,0,32'h0,  0,0);
    step(0,1, 0,0,0, 0,32'h0,   1,32'h102, 0, 32'h100, 1,1,0,32'h0,  0,0);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h180, 1,1,1,32'h102,0,0);
    step(0,1, 0,0,0, 1,32'h41,  0,32'h0,   0, 32'h184, 1,0,0,32'h102,0,0);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h180, 1,1,1,32'h41, 0,0);
    step(0,1, 0,0,0, 0,32'h0,   1,32'h20,  0, 32'h184, 1,0,0,32'h41, 0,0);
    // Halt, ignored requests, resume, halt+resume, exception wake-up.
    step(0,1, 0,1,0, 0,32'h0,   0,32'h0,   0, 32'h20,  1,1,0,32'h41, 0,0);
    step(0,1, 0,0,0, 0,32'h0,   1,32'h300, 0, 32'h24,  0,0,0,32'h41, 0,0);
    step(0,1, 1,0,0, 1,32'h400, 0,32'h0,   0, 32'h24,  0,0,0,32'h41, 0,0);
    step(0,1, 0,0,1, 0,32'h0,   0,32'h0,   0, 32'h24,  0,0,0,32'h41, 0,0);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h24,  1,0,0,32'h41, 0,0);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h28,  1,0,0,32'h41, 0,0);
    step(0,1, 0,1,0, 0,32'h0,   0,32'h0,   0, 32'h2C,  1,0,0,32'h41, 0,0);
    step(0,1, 0,1,1, 0,32'h0,   0,32'h0,   0, 32'h30,  0,0,0,32'h41, 0,0);
    step(0,1, 0,1,0, 0,32'h0,   0,32'h0,   0, 32'h30,  1,0,0,32'h41, 0,0);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   1, 32'h34,  0,0,0,32'h41, 0,0);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h180, 1,1,0,32'h41, 0,0);
    step(0,1, 0,1,0, 0,32'h0,   0,32'h0,   1, 32'h184, 1,0,0,32'h41, 0,0);
    step(0,1, 1,0,0, 0,32'h0,   0,32'h0,   0, 32'h180, 0,1,0,32'h41, 0,0);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h180, 1,0,0,32'h41, 0,0);
    // Mid-cycle reset clears everything before the next edge.
    step(0,0, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h0,   0,0,0,32'h0,  0,0);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h0,   0,0,0,32'h0,  0,0);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h0,   1,0,0,32'h0,  0,0);
    // 8-bit instance: wrap at 0xFC, truncated exception vector 0x80, misalignment.
    step(1,0, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h0,   0,0,0,32'h0,  0,0);
    step(1,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h0,   0,0,0,32'h0,  0,0);
    step(1,1, 0,0,0, 0,32'h0,   1,32'hFC,  0, 32'h0,   1,0,0,32'h0,  0,0);
    step(1,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'hFC,  1,1,0,32'h0,  0,0);
    step(1,1, 0,0,0, 0,32'h0,   0,32'h0,   1, 32'h0,   1,0,0,32'h0,  0,0);
    step(1,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h80,  1,1,0,32'h0,  0,0);
    step(1,1, 0,0,0, 0,32'h0,   1,32'h83,  0, 32'h84,  1,0,0,32'h0,  0,0);
    step(1,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h80,  1,1,1,32'h83, 0,0);
    step(1,0, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h0,   0,0,0,32'h0,  0,0);
    // Fetch counting: 5 run, 2 stall, 3 run cycles after reset -> 8.
    step(0,0, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h0,   0,0,0,32'h0,  1,0);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h0,   0,0,0,32'h0,  1,0);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h0,   1,0,0,32'h0,  1,0);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h4,   1,0,0,32'h0,  1,1);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h8,   1,0,0,32'h0,  1,2);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'hC,   1,0,0,32'h0,  1,3);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h10,  1,0,0,32'h0,  1,4);
    step(0,1, 1,0,0, 0,32'h0,   0,32'h0,   0, 32'h14,  0,0,0,32'h0,  1,5);
    step(0,1, 1,0,0, 0,32'h0,   0,32'h0,   0, 32'h14,  0,0,0,32'h0,  1,5);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h14,  1,0,0,32'h0,  1,5);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h18,  1,0,0,32'h0,  1,6);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h1C,  1,0,0,32'h0,  1,7);
    step(0,1, 0,0,0, 0,32'h0,   0,32'h0,   0, 32'h20,  1,0,0,32'h0,  1,8);

    // Let the monitor drain the scoreboard, bounded.
    n = 0;
    @(negedge clk);
    while (sb.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end else begin
      passed++;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
